// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: picks the narrowest permitted 20-bit immediate form,
// with valid/ready flow on both sides and saturating per-form usage counters.
module imm_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [19:0]      in_value,
   input  logic [4:0]       allow_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_select,
   output logic [19:0]      out_field,
   input  logic [2:0]       cnt_sel,
   input  logic             cnt_clear,
   output logic [CNT_W-1:0] cnt_value
);

   localparam logic [2:0] SEL_SIGN5  = 3'b000;
   localparam logic [2:0] SEL_SIGN15 = 3'b001;
   localparam logic [2:0] SEL_ZERO5  = 3'b010;
   localparam logic [2:0] SEL_ZERO15 = 3'b011;
   localparam logic [2:0] SEL_FULL   = 3'b100;

   logic             s1_valid;
   logic [19:0]      s1_value;
   logic [3:0]       s1_mask;
   logic             s1_load;
   logic             s2_load;
   logic             out_hs;
   logic             mask_unused;
   logic             fit_zero5;
   logic             fit_sign5;
   logic             fit_zero15;
   logic             fit_sign15;
   logic [2:0]       cls_select;
   logic [19:0]      cls_field;
   logic [CNT_W-1:0] cnt [5];

   // The full form is always legal, so its mask bit carries no information.
   assign mask_unused = allow_mask[4];

   assign s2_load  = !out_valid | out_ready;
   assign in_ready = !s1_valid | s2_load;
   assign s1_load  = in_valid & in_ready;
   assign out_hs   = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_value <= '0;
         s1_mask  <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_value <= in_value;
         s1_mask  <= allow_mask[3:0];
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   assign fit_zero5  = (s1_value[19:5] == '0);
   assign fit_sign5  = (&s1_value[19:4]) | ~(|s1_value[19:4]);
   assign fit_zero15 = (s1_value[19:15] == '0);
   assign fit_sign15 = (&s1_value[19:14]) | ~(|s1_value[19:14]);

   // 5-bit forms duplicate the payload so the extender can tap either half.
   always_comb begin
      cls_select = SEL_FULL;
      cls_field  = s1_value;
      if (s1_mask[2] && fit_zero5) begin
         cls_select = SEL_ZERO5;
         cls_field  = {5'b0, s1_value[4:0], 5'b0, s1_value[4:0]};
      end else if (s1_mask[0] && fit_sign5) begin
         cls_select = SEL_SIGN5;
         cls_field  = {5'b0, s1_value[4:0], 5'b0, s1_value[4:0]};
      end else if (s1_mask[3] && fit_zero15) begin
         cls_select = SEL_ZERO15;
         cls_field  = {5'b0, s1_value[14:0]};
      end else if (s1_mask[1] && fit_sign15) begin
         cls_select = SEL_SIGN15;
         cls_field  = {5'b0, s1_value[14:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_select <= 3'b000;
         out_field  <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_select <= cls_select;
            out_field  <= cls_field;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clear) begin
         for (int i = 0; i < 5; i++) cnt[i] <= '0;
      end else if (out_hs) begin
         for (int i = 0; i < 5; i++) begin
            if (out_select == 3'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_value <= '0;
      end else begin
         case (cnt_sel)
            3'd0:    cnt_value <= cnt[0];
            3'd1:    cnt_value <= cnt[1];
            3'd2:    cnt_value <= cnt[2];
            3'd3:    cnt_value <= cnt[3];
            3'd4:    cnt_value <= cnt[4];
            default: cnt_value <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed + randomized bench for imm_encoder: scoreboard of expected encodings,
// counter model, backpressure, clear and reset scenarios.
module tb_imm_encoder;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [19:0]      in_value;
   logic [4:0]       allow_mask;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out_select;
   logic [19:0]      out_field;
   logic [2:0]       cnt_sel;
   logic             cnt_clear;
   logic [CNT_W-1:0] cnt_value;

   always #5 clk = ~clk;

   imm_encoder #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_value   (in_value),
      .allow_mask (allow_mask),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_select (out_select),
      .out_field  (out_field),
      .cnt_sel    (cnt_sel),
      .cnt_clear  (cnt_clear),
      .cnt_value  (cnt_value)
   );

   int          checks = 0;
   int          errors = 0;
   logic [22:0] q [$];
   logic [22:0] cur_exp;
   int          model_cnt [5];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] extend(input logic [2:0] sel, input logic [19:0] f);
      case (sel)
         3'b010:  return {15'b0, f[4:0]};
         3'b000:  return {{15{f[4]}}, f[4:0]};
         3'b011:  return {5'b0, f[14:0]};
         3'b001:  return {{5{f[14]}}, f[14:0]};
         default: return f;
      endcase
   endfunction

   // Try each narrow form in priority order; keep the first one that round-trips.
   function automatic logic [22:0] model(input logic [19:0] v, input logic [4:0] m);
      logic [2:0]  order [4];
      logic [2:0]  sel;
      logic [19:0] f;
      order[0] = 3'd2; order[1] = 3'd0; order[2] = 3'd3; order[3] = 3'd1;
      for (int k = 0; k < 4; k++) begin
         sel = order[k];
         if (m[sel]) begin
            f = (sel == 3'd2 || sel == 3'd0) ? {5'b0, v[4:0], 5'b0, v[4:0]} : {5'b0, v[14:0]};
            if (extend(sel, f) == v) return {sel, f};
         end
      end
      return {3'd4, v};
   endfunction

   task automatic cycle(output bit acc);
      logic [22:0] e;
      @(negedge clk);
      acc = 1'b0;
      if (rst) begin
         q.delete();
         for (int i = 0; i < 5; i++) model_cnt[i] = 0;
      end else begin
         if (out_valid && out_ready) begin
            check("out_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("out_select", 32'(out_select), 32'(e[22:20]));
               check("out_field", 32'(out_field), 32'(e[19:0]));
            end
         end
         if (cnt_clear) begin
            for (int i = 0; i < 5; i++) model_cnt[i] = 0;
         end else if (out_valid && out_ready && out_select < 3'd5) begin
            if (model_cnt[out_select] < (2**CNT_W - 1)) model_cnt[out_select]++;
         end
         if (in_valid && in_ready) begin
            q.push_back(cur_exp);
            acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [19:0] v, input logic [4:0] m, input logic [22:0] exp);
      bit acc;
      in_valid   = 1'b1;
      in_value   = v;
      allow_mask = m;
      cur_exp    = exp;
      acc        = 1'b0;
      for (int n = 0; n < 50 && !acc; n++) cycle(acc);
      check("accepted", 32'(acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      bit acc;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (n) cycle(acc);
   endtask

   task automatic read_cnt(input logic [2:0] sel);
      bit acc;
      cnt_sel = sel;
      cycle(acc);
      cycle(acc);
      check("cnt_model", 32'(cnt_value), (sel < 3'd5) ? 32'(model_cnt[sel]) : 32'd0);
   endtask

   initial begin
      bit          acc;
      logic [19:0] v;
      logic [4:0]  m;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_value   = '0;
      allow_mask = '0;
      out_ready  = 1'b1;
      cnt_sel    = 3'd0;
      cnt_clear  = 1'b0;
      cur_exp    = '0;
      for (int i = 0; i < 5; i++) model_cnt[i] = 0;
      repeat (3) cycle(acc);
      rst = 1'b0;

      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_select", 32'(out_select), 32'd0);
      check("rst_out_field", 32'(out_field), 32'd0);
      check("rst_cnt_value", 32'(cnt_value), 32'd0);

      // Latency: accepted on the first edge, visible after the second.
      in_valid = 1'b1; in_value = 20'h00007; allow_mask = 5'b11111;
      cur_exp = {3'b010, 20'h01C07};
      cycle(acc);
      check("lat_accept", 32'(acc), 32'd1);
      in_valid = 1'b0;
      check("lat_stage1_only", 32'(out_valid), 32'd0);
      cycle(acc);
      check("lat_out_valid", 32'(out_valid), 32'd1);
      check("lat_select", 32'(out_select), 32'h2);
      check("lat_field", 32'(out_field), 32'h01C07);
      drain(3);

      send(20'hFFFF9, 5'b11111, {3'b000, 20'h06419});
      send(20'h01234, 5'b11111, {3'b011, 20'h01234});
      send(20'hFC000, 5'b11111, {3'b001, 20'h04000});
      send(20'h80000, 5'b11111, {3'b100, 20'h80000});
      send(20'h00007, 5'b01000, {3'b011, 20'h00007});
      send(20'h00007, 5'b00000, {3'b100, 20'h00007});
      drain(4);

      // Backpressure: fill both stages, hold, then release.
      out_ready = 1'b0;
      in_valid = 1'b1; in_value = 20'h00001; allow_mask = 5'b11111;
      cur_exp = {3'b010, 20'h00401};
      cycle(acc);
      check("bp_accept1", 32'(acc), 32'd1);
      in_value = 20'h00002; cur_exp = {3'b010, 20'h00802};
      cycle(acc);
      check("bp_accept2", 32'(acc), 32'd1);
      in_value = 20'h00003; cur_exp = {3'b010, 20'h00C03};
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      repeat (3) begin
         cycle(acc);
         check("bp_no_accept", 32'(acc), 32'd0);
         check("bp_stable_select", 32'(out_select), 32'h2);
         check("bp_stable_field", 32'(out_field), 32'h00401);
         check("bp_in_ready_held", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 10 && !acc; n++) cycle(acc);
      check("bp_accept3", 32'(acc), 32'd1);
      drain(4);
      check("bp_queue_empty", 32'(q.size()), 32'd0);

      // Three zero5 handshakes after a clear.
      cnt_clear = 1'b1; cycle(acc); cnt_clear = 1'b0;
      repeat (3) send(20'h00005, 5'b11111, {3'b010, 20'h01405});
      drain(3);
      cnt_sel = 3'd2; cycle(acc); cycle(acc);
      check("cnt_zero5_three", 32'(cnt_value), 32'd3);
      read_cnt(3'd4);

      // Clear coincident with a handshake.
      out_ready = 1'b0;
      send(20'h00005, 5'b11111, {3'b010, 20'h01405});
      cycle(acc);
      check("clr_pending", 32'(out_valid), 32'd1);
      out_ready = 1'b1; cnt_clear = 1'b1;
      cycle(acc);
      cnt_clear = 1'b0;
      drain(2);
      cnt_sel = 3'd2; cycle(acc); cycle(acc);
      check("cnt_clear_wins", 32'(cnt_value), 32'd0);

      // Saturation of the narrow test counter.
      repeat (20) send(20'h80000, 5'b00000, {3'b100, 20'h80000});
      drain(3);
      cnt_sel = 3'd4; cycle(acc); cycle(acc);
      check("cnt_saturate", 32'(cnt_value), 32'd15);
      cnt_sel = 3'd5; cycle(acc); cycle(acc);
      check("cnt_sel_oob", 32'(cnt_value), 32'd0);

      // Randomized stream with random backpressure.
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 4))
            0:       v = 20'($urandom_range(0, 31));
            1:       v = 20'hFFFFF - 20'($urandom_range(0, 15));
            2:       v = 20'($urandom_range(0, 32767));
            3:       v = 20'hFFFFF - 20'($urandom_range(0, 16383));
            default: v = 20'($urandom);
         endcase
         m = 5'($urandom_range(0, 31));
         in_valid = 1'b1; in_value = v; allow_mask = m; cur_exp = model(v, m);
         acc = 1'b0;
         for (int n = 0; n < 200 && !acc; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle(acc);
         end
         check("rnd_accepted", 32'(acc), 32'd1);
         in_valid = 1'b0;
         if ($urandom_range(0, 3) == 0) cycle(acc);
      end
      drain(5);
      check("rnd_queue_empty", 32'(q.size()), 32'd0);
      for (int s = 0; s < 8; s++) read_cnt(3'(s));

      // Reset with both stages full and a coincident handshake.
      out_ready = 1'b0;
      send(20'h00009, 5'b11111, {3'b010, 20'h02409});
      send(20'h80001, 5'b11111, {3'b100, 20'h80001});
      check("rst_mid_full", 32'(in_ready), 32'd0);
      rst = 1'b1; out_ready = 1'b1;
      cycle(acc);
      rst = 1'b0;
      repeat (4) begin
         cycle(acc);
         check("rst_mid_no_out", 32'(out_valid), 32'd0);
      end
      cnt_sel = 3'd4; cycle(acc); cycle(acc);
      check("rst_mid_cnt4", 32'(cnt_value), 32'd0);
      for (int s = 0; s < 5; s++) read_cnt(3'(s));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
